// File: rtl/cnt25_checker.sv
`default_nettype none
// ============================================================================
//  Module      : cnt25_checker
//  Description : Tracks an upstream mod-MOD counter stream. Acquires lock after
//                LOCK_N consecutive +1 steps. While locked, counts and flags
//                mismatches and drops lock after ERR_THRESH consecutive
//                mismatches.
//                Optional wrap detector: define CNT25_CHECKER_WRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt25_checker #(
    parameter int MOD        = 25,
    parameter int LOCK_N     = 2,
    parameter int ERR_THRESH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [4:0]  in_data,
    output logic        locked,
    output logic        err_pulse,
    output logic [7:0]  err_cnt,
    output logic        wrap_pulse,
    output logic [15:0] wrap_cnt
);

    localparam logic [5:0] c_MOD_EXT = 6'(MOD);
    localparam logic [4:0] c_TOP     = 5'(MOD - 1);
    localparam logic [3:0] c_LOCK_N  = 4'(LOCK_N);
    localparam logic [3:0] c_ERR_TH  = 4'(ERR_THRESH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  last_q, last_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  run_q, run_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        w_in_range;
    logic [4:0]  w_expected;
    logic        w_match;

    // Expected next value of the upstream counter and match qualification.
    assign w_in_range = {1'b0, in_data} < c_MOD_EXT;
    assign w_expected = (last_q == c_TOP) ? 5'd0 : last_q + 5'd1;
    assign w_match    = w_in_range && (in_data == w_expected);

    // Next-state and output logic; all updates gated by in_valid.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        match_d   = match_q;
        run_d     = run_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (in_valid) begin
            case (state_q)
                S_IDLE, S_LOST: begin
                    if (w_in_range) begin
                        last_d  = in_data;
                        match_d = 4'd0;
                        state_d = S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    last_d = in_data;
                    if (w_match) begin
                        if (match_q + 4'd1 == c_LOCK_N) begin
                            match_d = 4'd0;
                            run_d   = 4'd0;
                            state_d = S_LOCKED;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        match_d = 4'd0;
                        if (!w_in_range) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_LOCKED: begin
                    // A glitch does not disturb the phase: expected advances anyway.
                    last_d = w_expected;
                    if (w_match) begin
                        run_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (run_q + 4'd1 == c_ERR_TH) begin
                            run_d   = 4'd0;
                            state_d = S_LOST;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign locked_d = (state_d == S_LOCKED);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= 5'd0;
            match_q   <= 4'd0;
            run_q     <= 4'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            match_q   <= match_d;
            run_q     <= run_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_q;
    assign err_cnt   = err_cnt_q;

`ifdef CNT25_CHECKER_WRAP_EN
    logic        w_wrap;
    logic        wrap_q;
    logic [15:0] wrap_cnt_q;

    // A wrap is a matching 0 that follows an accepted MOD-1 while locked.
    assign w_wrap = in_valid && (state_q == S_LOCKED) && w_match && (last_q == c_TOP);

    // Wrap pulse and free-rolling wrap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q     <= 1'b0;
            wrap_cnt_q <= 16'd0;
        end else begin
            wrap_q <= w_wrap;
            if (w_wrap) begin
                wrap_cnt_q <= wrap_cnt_q + 16'd1;
            end
        end
    end

    assign wrap_pulse = wrap_q;
    assign wrap_cnt   = wrap_cnt_q;
`else
    assign wrap_pulse = 1'b0;
    assign wrap_cnt   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnt25_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt25_checker
//  Description : Self-checking bench for cnt25_checker (directed stimulus,
//                behavioural reference model, per-cycle compare).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt25_checker;

    localparam int MOD        = 25;
    localparam int LOCK_N     = 2;
    localparam int ERR_THRESH = 3;
`ifdef CNT25_CHECKER_WRAP_EN
    localparam int WRAP = 1;
`else
    localparam int WRAP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_data;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        wrap_pulse;
    logic [15:0] wrap_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    cnt25_checker #(
        .MOD        (MOD),
        .LOCK_N     (LOCK_N),
        .ERR_THRESH (ERR_THRESH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 acquiring, 2 locked, 3 lost
    int m_phase = 0;
    int m_last = 0, m_hits = 0, m_misses = 0;
    int e_errcnt = 0, e_wrapcnt = 0;
    bit e_locked = 0, e_err = 0, e_wrap = 0;

    task automatic model_reset();
        m_phase = 0; m_last = 0; m_hits = 0; m_misses = 0;
        e_errcnt = 0; e_wrapcnt = 0;
        e_locked = 0; e_err = 0; e_wrap = 0;
    endtask

    task automatic model_step(input bit v, input int d);
        int  nxt;
        bit  ok;
        e_err  = 0;
        e_wrap = 0;
        if (v) begin
            nxt = (m_last + 1) % MOD;
            ok  = (d < MOD) && (d == nxt);
            case (m_phase)
                0, 3: begin
                    if (d < MOD) begin
                        m_last = d; m_hits = 0; m_phase = 1;
                    end
                end
                1: begin
                    m_last = d;
                    if (ok) begin
                        m_hits++;
                        if (m_hits == LOCK_N) begin
                            m_phase = 2; m_misses = 0;
                        end
                    end else begin
                        m_hits = 0;
                        if (d >= MOD) m_phase = 0;
                    end
                end
                default: begin
                    if (ok) begin
                        if (WRAP == 1 && m_last == MOD - 1 && d == 0) begin
                            e_wrap = 1;
                            e_wrapcnt = (e_wrapcnt + 1) % 65536;
                        end
                        m_misses = 0;
                    end else begin
                        e_err = 1;
                        if (e_errcnt < 255) e_errcnt++;
                        m_misses++;
                        if (m_misses == ERR_THRESH) m_phase = 3;
                    end
                    m_last = nxt;
                end
            endcase
        end
        e_locked = (m_phase == 2);
    endtask

    // Model advances on the same edges the DUT sees.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(in_valid, int'(in_data));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc.locked",     int'(locked),     int'(e_locked));
            chk("cyc.err_pulse",  int'(err_pulse),  int'(e_err));
            chk("cyc.err_cnt",    int'(err_cnt),    e_errcnt);
            chk("cyc.wrap_pulse", int'(wrap_pulse), int'(e_wrap));
            chk("cyc.wrap_cnt",   int'(wrap_cnt),   e_wrapcnt);
            if (err_pulse && wrap_pulse) chk("cyc.both_pulses", 1, 0);
        end
    end

    // Drive one cycle (called at a negedge, returns at the next negedge).
    task automatic send(input bit v, input int d);
        in_valid = v;
        in_data  = 5'(d);
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 5'd0;
        #1 rst_n = 1'b0;
        cmp_en   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.locked",  int'(locked),  0);
        chk("rst.err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;

        // out-of-range in IDLE, then lock-up on 0,1,2
        send(1, 30);  chk("idle.oor.locked", int'(locked), 0);
        send(1, 0);
        send(1, 1);   chk("acq.locked_after1", int'(locked), 0);
        send(1, 2);   chk("lock.locked", int'(locked), 1);
        chk("lock.err_cnt", int'(err_cnt), 0);

        // climb to the wrap
        for (int v = 3; v <= 21; v++) send(1, v);
        send(1, 22); send(1, 23); send(1, 24);
        send(1, 0);   chk("wrap.pulse", int'(wrap_pulse), WRAP);
        chk("wrap.cnt", int'(wrap_cnt), WRAP);
        send(1, 1);   chk("wrap.pulse_off", int'(wrap_pulse), 0);

        // single glitch: 5,6,9,8
        send(1, 2); send(1, 3); send(1, 4); send(1, 5); send(1, 6);
        send(1, 9);   chk("glitch.err_pulse", int'(err_pulse), 1);
        chk("glitch.err_cnt", int'(err_cnt), 1);
        chk("glitch.locked", int'(locked), 1);
        send(1, 8);   chk("glitch.pulse_off", int'(err_pulse), 0);
        // run must have been cleared by 8: two more misses keep lock
        send(1, 31); send(1, 31);
        send(1, 11);  chk("runclr.locked", int'(locked), 1);
        chk("runclr.err_cnt", int'(err_cnt), 3);

        // loss of lock
        send(1, 31); send(1, 31);
        chk("lost.still_locked", int'(locked), 1);
        send(1, 31);  chk("lost.locked", int'(locked), 0);
        chk("lost.err_cnt", int'(err_cnt), 6);
        send(1, 31);  chk("lost.no_count", int'(err_cnt), 6);
        send(1, 10);  chk("reacq.locked", int'(locked), 0);
        send(1, 11);
        send(1, 12);  chk("relock.locked", int'(locked), 1);

        // continue through a second wrap to 3, then gaps
        for (int v = 13; v <= 24; v++) send(1, v);
        send(1, 0); send(1, 1); send(1, 2);
        chk("wrap2.cnt", int'(wrap_cnt), 2 * WRAP);
        send(1, 3);
        gap(4);
        send(1, 4);
        send(1, 5);   chk("gap.locked", int'(locked), 1);
        chk("gap.err_cnt", int'(err_cnt), 6);

        // asynchronous reset mid-stream
        in_valid = 1'b1;
        in_data  = 5'd6;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.locked",   int'(locked),     0);
        chk("arst.err_cnt",  int'(err_cnt),    0);
        chk("arst.wrap_cnt", int'(wrap_cnt),   0);
        chk("arst.err_p",    int'(err_pulse),  0);
        @(negedge clk);
        send(1, 7);   chk("arst.hold", int'(locked), 0);
        rst_n = 1'b1;

        // saturation: 100 rounds of relock + three misses
        for (int r = 0; r < 100; r++) begin
            send(1, 0); send(1, 1); send(1, 2);
            send(1, 31); send(1, 31); send(1, 31);
            if (r == 49) chk("sat.mid", int'(err_cnt), 150);
        end
        chk("sat.err_cnt", int'(err_cnt), 255);
        chk("sat.locked",  int'(locked),  0);

        gap(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
